// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one synchronous-read ROM between two
// requesters. Define ROM_ARB_STATS_EN to add the CNT_A/CNT_B access counters.
module rom_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ_A,
  input  logic [ADDR_WIDTH-1:0] ADDR_A,
  output logic                  GNT_A,
  output logic [DATA_WIDTH-1:0] DATA_A,
  output logic                  VALID_A,
  input  logic                  REQ_B,
  input  logic [ADDR_WIDTH-1:0] ADDR_B,
  output logic                  GNT_B,
  output logic [DATA_WIDTH-1:0] DATA_B,
  output logic                  VALID_B,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] CNT_A,
  output logic [STAT_WIDTH-1:0] CNT_B
`endif
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, DONE} state_t;

  state_t                state, state_next;
  logic                  sel, sel_next;    // 0 = port A, 1 = port B
  logic                  last, last_next;  // port served most recently
  logic                  any_req, pick_b;
  logic [ADDR_WIDTH-1:0] rom_addr_next;
  logic                  gnt_a_next, gnt_b_next;
  logic                  valid_a_next, valid_b_next;
  logic [DATA_WIDTH-1:0] data_a_next, data_b_next;

  if (ADDR_WIDTH < 1 || DATA_WIDTH < 1 || STAT_WIDTH < 1) begin : g_param_check
    $error("rom_arbiter: all widths must be positive");
  end

  assign any_req = REQ_A | REQ_B;
  // B wins if it asks alone, or on a tie when A was served last.
  assign pick_b  = REQ_B & (~REQ_A | ~last);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req) state_next = READ;
      READ:    state_next = CAPT;
      CAPT:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_next      = sel;
    last_next     = last;
    rom_addr_next = ROM_ADDR;
    gnt_a_next    = GNT_A;
    gnt_b_next    = GNT_B;
    valid_a_next  = VALID_A;
    valid_b_next  = VALID_B;
    data_a_next   = DATA_A;
    data_b_next   = DATA_B;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          sel_next      = pick_b;
          rom_addr_next = pick_b ? ADDR_B : ADDR_A;
          gnt_a_next    = ~pick_b;
          gnt_b_next    = pick_b;
        end
      end
      CAPT: begin
        last_next = sel;
        if (sel) begin
          data_b_next  = ROM_DATA;
          valid_b_next = 1'b1;
          gnt_b_next   = 1'b0;
        end else begin
          data_a_next  = ROM_DATA;
          valid_a_next = 1'b1;
          gnt_a_next   = 1'b0;
        end
      end
      DONE: begin
        valid_a_next = 1'b0;
        valid_b_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel      <= 1'b0;
      last     <= 1'b1;
      ROM_ADDR <= '0;
      GNT_A    <= 1'b0;
      GNT_B    <= 1'b0;
      VALID_A  <= 1'b0;
      VALID_B  <= 1'b0;
      DATA_A   <= '0;
      DATA_B   <= '0;
    end else begin
      sel      <= sel_next;
      last     <= last_next;
      ROM_ADDR <= rom_addr_next;
      GNT_A    <= gnt_a_next;
      GNT_B    <= gnt_b_next;
      VALID_A  <= valid_a_next;
      VALID_B  <= valid_b_next;
      DATA_A   <= data_a_next;
      DATA_B   <= data_b_next;
    end
  end

`ifdef ROM_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CNT_A <= '0;
      CNT_B <= '0;
    end else begin
      if (VALID_A) CNT_A <= CNT_A + STAT_WIDTH'(1);
      if (VALID_B) CNT_B <= CNT_B + STAT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a transaction-level reference model and
// a per-cycle output comparator. Honours ROM_ARB_STATS_EN like the design.
module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       reset, req_a, req_b;
  logic [7:0] addr_a, addr_b;
  logic       gnt_a, gnt_b, valid_a, valid_b;
  logic [7:0] data_a, data_b, rom_addr, rom_data;
`ifdef ROM_ARB_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STAT_WIDTH(16)) dut (
    .CLK(clk), .RESET(reset),
    .REQ_A(req_a), .ADDR_A(addr_a), .GNT_A(gnt_a), .DATA_A(data_a), .VALID_A(valid_a),
    .REQ_B(req_b), .ADDR_B(addr_b), .GNT_B(gnt_b), .DATA_B(data_b), .VALID_B(valid_b),
    .ROM_ADDR(rom_addr), .ROM_DATA(rom_data)
`ifdef ROM_ARB_STATS_EN
    , .CNT_A(cnt_a), .CNT_B(cnt_b)
`endif
  );

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // ROM with one-cycle registered read.
  always @(posedge clk) rom_data <= rom_val(rom_addr);

  // Reference model: a granted access occupies four edges; data lands on the
  // third edge after grant and no new grant is possible until the fourth.
  logic        m_live = 1'b0;
  logic        m_active, m_sel, m_last;
  int          m_age;
  logic [7:0]  e_addr;
  logic        e_gnt   [2];
  logic        e_valid [2];
  logic [7:0]  e_data  [2];
  logic [15:0] e_cnt   [2];

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_live = 1'b1; m_active = 1'b0; m_sel = 1'b0; m_last = 1'b1; m_age = 0;
      e_addr = 8'h00;
      for (int p = 0; p < 2; p++) begin
        e_gnt[p] = 1'b0; e_valid[p] = 1'b0; e_data[p] = 8'h00; e_cnt[p] = 16'h0;
      end
    end else if (m_active) begin
      m_age++;
      if (m_age == 2) begin
        e_data[m_sel] = rom_val(e_addr);
        e_valid[m_sel] = 1'b1;
        e_gnt[m_sel] = 1'b0;
        m_last = m_sel;
      end else if (m_age == 3) begin
        e_valid[m_sel] = 1'b0;
        e_cnt[m_sel]++;
        m_active = 1'b0;
      end
    end else if (req_a || req_b) begin
      m_sel = (req_a && req_b) ? ~m_last : req_b;
      e_addr = m_sel ? addr_b : addr_a;
      e_gnt[m_sel] = 1'b1;
      m_active = 1'b1;
      m_age = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("gnt_a",    32'(gnt_a),    32'(e_gnt[0]));
      chk("gnt_b",    32'(gnt_b),    32'(e_gnt[1]));
      chk("valid_a",  32'(valid_a),  32'(e_valid[0]));
      chk("valid_b",  32'(valid_b),  32'(e_valid[1]));
      chk("data_a",   32'(data_a),   32'(e_data[0]));
      chk("data_b",   32'(data_b),   32'(e_data[1]));
      chk("gnt_excl",   32'(gnt_a & gnt_b),     32'(0));
      chk("valid_excl", 32'(valid_a & valid_b), 32'(0));
`ifdef ROM_ARB_STATS_EN
      chk("cnt_a", 32'(cnt_a), 32'(e_cnt[0]));
      chk("cnt_b", 32'(cnt_b), 32'(e_cnt[1]));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input bit port_b, input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if ((port_b ? valid_b : valid_a) === 1'b1) begin
        n = i;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_valid_%s: no pulse within %0d cycles", port_b ? "b" : "a", limit);
  endtask

  task automatic single_access(input bit port_b, input logic [7:0] addr);
    int n;
    if (port_b) begin req_b = 1'b1; addr_b = addr; end
    else        begin req_a = 1'b1; addr_a = addr; end
    wait_valid(port_b, 10, n);
    chk("single_data", 32'(port_b ? data_b : data_a), 32'(rom_val(addr)));
    req_a = 1'b0;
    req_b = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int   n;
  int   order [$];
  logic prev_a, prev_b;

  initial begin
    // Reset with both requests pending; first grant after release goes to A.
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1; addr_a = 8'h44; addr_b = 8'h33;
    step();
    chk("rst_gnt_a", 32'(gnt_a), 32'(0));
    chk("rst_gnt_b", 32'(gnt_b), 32'(0));
    step();
    chk("rst_rom_addr", 32'(rom_addr), 32'(0));
    chk("rst_data_a", 32'(data_a), 32'(0));
    reset = 1'b0;
    step();
    chk("first_gnt_a", 32'(gnt_a), 32'(1));
    chk("first_gnt_b", 32'(gnt_b), 32'(0));
    // Requests dropped during READ: the access still completes.
    req_a = 1'b0; req_b = 1'b0;
    wait_valid(1'b0, 8, n);
    chk("drop_lat", 32'(n), 32'(2));
    chk("drop_data", 32'(data_a), 32'h0000_00E1);
    step(); step();

    // Single A access; address change after grant is ignored.
    req_a = 1'b1; addr_a = 8'h10;
    step();
    chk("t2_gnt_a", 32'(gnt_a), 32'(1));
    addr_a = 8'h77;
    step();
    chk("t2_valid_early", 32'(valid_a), 32'(0));
    step();
    chk("t2_valid_a", 32'(valid_a), 32'(1));
    chk("t2_data_a", 32'(data_a), 32'h0000_00B5);
    chk("t2_valid_b", 32'(valid_b), 32'(0));
    req_a = 1'b0;
    step();
    chk("t2_pulse_end", 32'(valid_a), 32'(0));
    step();

    // Simultaneous requests from reset: A first, B four cycles later.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_a = 1'b1; req_b = 1'b1; addr_a = 8'h01; addr_b = 8'hFF;
    wait_valid(1'b0, 8, n);
    chk("t3_data_a", 32'(data_a), 32'h0000_00A4);
    req_a = 1'b0;
    wait_valid(1'b1, 8, n);
    chk("t3_gap", 32'(n), 32'(4));
    chk("t3_data_b", 32'(data_b), 32'h0000_005A);
    req_b = 1'b0;
    step(); step();

    // Both requesters busy, each dropping REQ for the cycle after VALID.
    addr_a = 8'h02; addr_b = 8'h80;
    prev_a = 1'b0; prev_b = 1'b0;
    for (int c = 0; c < 100 && order.size() < 8; c++) begin
      req_a = ~valid_a;
      req_b = ~valid_b;
      step();
      if (gnt_a && !prev_a) order.push_back(0);
      if (gnt_b && !prev_b) order.push_back(1);
      prev_a = gnt_a;
      prev_b = gnt_b;
    end
    chk("t4_grants", 32'(order.size()), 32'(8));
    for (int i = 0; i < order.size(); i++) chk("t4_order", 32'(order[i]), 32'(i % 2));
    req_a = 1'b0; req_b = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Reset while a B access sits in CAPT discards it.
    req_b = 1'b1; addr_b = 8'h30;
    step();
    chk("t5_gnt_b", 32'(gnt_b), 32'(1));
    step();
    reset = 1'b1;
    step();
    chk("t5_valid_b", 32'(valid_b), 32'(0));
    chk("t5_data_b", 32'(data_b), 32'(0));
    chk("t5_gnt_b_clr", 32'(gnt_b), 32'(0));
    chk("t5_rom_addr", 32'(rom_addr), 32'(0));
    reset = 1'b0; addr_b = 8'h20;
    wait_valid(1'b1, 8, n);
    chk("t5_data_after", 32'(data_b), 32'h0000_0085);
    req_b = 1'b0;
    step(); step();

`ifdef ROM_ARB_STATS_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) single_access(1'b0, 8'(i + 5));
    for (int i = 0; i < 5; i++) single_access(1'b1, 8'(i + 200));
    step(); step();
    chk("t6_cnt_a", 32'(cnt_a), 32'(3));
    chk("t6_cnt_b", 32'(cnt_b), 32'(5));
    reset = 1'b1;
    step();
    chk("t6_cnt_a_clr", 32'(cnt_a), 32'(0));
    chk("t6_cnt_b_clr", 32'(cnt_b), 32'(0));
    reset = 1'b0;
`else
    single_access(1'b0, 8'h5A);
    single_access(1'b1, 8'hC3);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
